// File: rtl/edge_detect_array.sv
// edge_detect_array: per-channel input synchroniser, optional glitch filter, edge pulses, sticky pending, irq.
// Latency: a stable new input reaches rise/down SYNC_STAGES+FILT_LEN-1 cycles after its sampling edge
//          when EDGE_DETECT_FILTER_EN is defined, SYNC_STAGES cycles when it is not (filter compiled out).
// Backpressure: none; pending is sticky until write-1-to-clear, and a new qualified edge beats a clr.
module edge_detect_array #(
   parameter int N_CH        = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   a,
   input  logic [2*N_CH-1:0] mode,
   input  logic [N_CH-1:0]   irq_en,
   input  logic [N_CH-1:0]   clr,
   output logic [N_CH-1:0]   rise,
   output logic [N_CH-1:0]   down,
   output logic [N_CH-1:0]   pending,
   output logic              irq
);

   // Parameter sanity marker: an illegal configuration shows up as g_illegal_params in the hierarchy.
   if (N_CH < 1 || SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_illegal_params
   end

   logic [N_CH-1:0] sync_q [SYNC_STAGES];
   logic [N_CH-1:0] sync_out;
   logic [N_CH-1:0] lvl_q;
   logic [N_CH-1:0] lvl_d;
   logic [N_CH-1:0] rise_d;
   logic [N_CH-1:0] down_d;
   logic [N_CH-1:0] mode_rise;
   logic [N_CH-1:0] mode_fall;
   logic [N_CH-1:0] qual_edge;
   logic [N_CH-1:0] pending_d;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Metastability synchroniser: every channel shifts through SYNC_STAGES flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q[0] <= a;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

`ifdef EDGE_DETECT_FILTER_EN
   localparam int            CW       = $clog2(FILT_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

   logic [CW-1:0] cnt_q [N_CH];
   logic [CW-1:0] cnt_d [N_CH];

   // Filter: adopt the synchronised value only after FILT_LEN consecutive disagreeing cycles.
   always_comb begin
      lvl_d = lvl_q;
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i] = '0;
         if (sync_out[i] != lvl_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               lvl_d[i] = sync_out[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Filter stability counters; reset discards any partial count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end
`else
   // No filter: the level follows the synchroniser output every cycle.
   always_comb begin
      lvl_d = sync_out;
   end
`endif

   // Per-channel edge-select bits: bit 2i enables rise, bit 2i+1 enables fall.
   for (genvar i = 0; i < N_CH; i++) begin : g_mode
      assign mode_rise[i] = mode[2*i];
      assign mode_fall[i] = mode[2*i+1];
   end

   // Edges are derived from the level about to be registered so the pulse lands on the same edge.
   assign rise_d    = lvl_d & ~lvl_q;
   assign down_d    = ~lvl_d & lvl_q;
   assign qual_edge = (rise_d & mode_rise) | (down_d & mode_fall);
   assign pending_d = (pending & ~clr) | qual_edge;

   // Filtered level, one-cycle edge pulses and sticky pending flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q   <= '0;
         rise    <= '0;
         down    <= '0;
         pending <= '0;
      end else begin
         lvl_q   <= lvl_d;
         rise    <= rise_d;
         down    <= down_d;
         pending <= pending_d;
      end
   end

   assign irq = |(pending & irq_en);

endmodule

// File: tb/tb_edge_detect_array.sv
// tb_edge_detect_array: directed vectors for edge_detect_array (N_CH=4, SYNC_STAGES=2, FILT_LEN=3).
// Expected edge timing follows EDGE_DETECT_FILTER_EN the same way the design does.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that point too.
module tb_edge_detect_array;

`ifdef EDGE_DETECT_FILTER_EN
   localparam int LAT  = 4;   // SYNC_STAGES + FILT_LEN - 1
   localparam bit FILT = 1'b1;
`else
   localparam int LAT  = 2;   // SYNC_STAGES
   localparam bit FILT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] a;
   logic [7:0] mode;
   logic [3:0] irq_en;
   logic [3:0] clr;
   logic [3:0] rise;
   logic [3:0] down;
   logic [3:0] pending;
   logic       irq;

   int checks = 0;
   int errors = 0;

   edge_detect_array #(
      .N_CH        (4),
      .SYNC_STAGES (2),
      .FILT_LEN    (3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a),
      .mode    (mode),
      .irq_en  (irq_en),
      .clr     (clr),
      .rise    (rise),
      .down    (down),
      .pending (pending),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      a      = 4'b0000;
      mode   = 8'b00_11_11_01;   // ch3 off, ch2 both, ch1 both, ch0 rise
      irq_en = 4'b0001;
      clr    = 4'b0000;

      // Reset state
      tick();
      tick();
      chk("rst_rise", rise, 4'b0000);
      chk("rst_down", down, 4'b0000);
      chk("rst_pending", pending, 4'b0000);
      chk("rst_irq", irq, 1'b0);
      rst_n = 1'b1;
      repeat (3) tick();

      // Channel 0 rise, pending, irq, clear
      a = 4'b0001;
      repeat (LAT) tick();
      chk("t1_rise_early", rise, 4'b0000);
      tick();
      chk("t1_rise", rise, 4'b0001);
      chk("t1_pending", pending, 4'b0001);
      chk("t1_irq", irq, 1'b1);
      tick();
      chk("t1_rise_one_cycle", rise, 4'b0000);
      chk("t1_pending_sticky", pending, 4'b0001);
      irq_en = 4'b0000;
      #1;
      chk("t1_irq_masked", irq, 1'b0);
      irq_en = 4'b0001;
      #1;
      chk("t1_irq_unmasked", irq, 1'b1);
      clr = 4'b0001;
      tick();
      clr = 4'b0000;
      chk("t1_pending_clr", pending, 4'b0000);
      chk("t1_irq_clr", irq, 1'b0);
      a = 4'b0000;
      repeat (8) tick();
      chk("t1_fall_unqualified", pending, 4'b0000);

      // Channel 1 two-cycle glitch
      a = 4'b0010;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (i == 2) a = 4'b0000;
         chk("t2_rise", rise, (!FILT && i == 3) ? 4'b0010 : 4'b0000);
         chk("t2_down", down, (!FILT && i == 5) ? 4'b0010 : 4'b0000);
      end
      chk("t2_pending", pending, FILT ? 4'b0000 : 4'b0010);
      clr = 4'b0010;
      tick();
      clr = 4'b0000;
      chk("t2_pending_clr", pending, 4'b0000);

      // Channel 2 both edges, clr colliding with the down pulse
      a = 4'b0100;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("t3_rise", rise, (i == 1 + LAT) ? 4'b0100 : 4'b0000);
         chk("t3_down", down, (i == 11 + LAT) ? 4'b0100 : 4'b0000);
         chk("t3_pending", pending, (i >= 1 + LAT) ? 4'b0100 : 4'b0000);
         chk("t3_irq", irq, 1'b0);
         if (i == 10) a = 4'b0000;
         if (i == 10 + LAT) clr = 4'b0100;
         if (i == 11 + LAT) clr = 4'b0000;
      end
      clr = 4'b0100;
      tick();
      clr = 4'b0000;
      chk("t3_pending_clr", pending, 4'b0000);

      // Channel 3 with mode off: pulses but no pending
      irq_en = 4'b1000;
      a = 4'b1000;
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (i == 6) a = 4'b0000;
         chk("t4_rise", rise, (i == 1 + LAT) ? 4'b1000 : 4'b0000);
         chk("t4_down", down, (i == 7 + LAT) ? 4'b1000 : 4'b0000);
         chk("t4_pending", pending, 4'b0000);
         chk("t4_irq", irq, 1'b0);
      end

      // All channels together
      mode   = 8'b01_01_01_01;
      irq_en = 4'b1111;
      a      = 4'b1111;
      repeat (LAT) tick();
      chk("t5_rise_early", rise, 4'b0000);
      tick();
      chk("t5_rise", rise, 4'b1111);
      chk("t5_pending", pending, 4'b1111);
      chk("t5_irq", irq, 1'b1);
      mode = 8'b00_00_00_00;
      tick();
      chk("t5_pending_mode_change", pending, 4'b1111);
      a = 4'b0000;
      repeat (LAT + 1) tick();
      chk("t5_down", down, 4'b1111);
      chk("t5_pending_keep", pending, 4'b1111);
      tick();
      chk("t5_down_one_cycle", down, 4'b0000);

      // Reset mid-filter, input held high across release
      mode = 8'b00_00_00_01;
      a    = 4'b0001;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("t6_rst_rise", rise, 4'b0000);
      chk("t6_rst_down", down, 4'b0000);
      chk("t6_rst_pending", pending, 4'b0000);
      chk("t6_rst_irq", irq, 1'b0);
      tick();
      rst_n = 1'b1;
      for (int i = 1; i <= LAT + 2; i++) begin
         tick();
         chk("t6_rise", rise, (i == LAT + 1) ? 4'b0001 : 4'b0000);
         chk("t6_pending", pending, (i >= LAT + 1) ? 4'b0001 : 4'b0000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/edge_detect_array.md
EDGE_DETECT_ARRAY -- requirements
Module: edge_detect_array

Interface
REQ-001 SHALL have parameter N_CH, 8, number of independent input channels (>=1).
REQ-002 SHALL have parameter SYNC_STAGES, 2, input synchroniser depth (>=2).
REQ-003 SHALL have parameter FILT_LEN, 4, glitch-filter stability length in cycles (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port a  input  N_CH  asynchronous channel inputs.
REQ-007 SHALL have port mode  input  2*N_CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-008 SHALL have port irq_en  input  N_CH  per-channel interrupt enable.
REQ-009 SHALL have port clr  input  N_CH  write-1-to-clear for pending.
REQ-010 SHALL have port rise  output  N_CH  one-cycle rising-edge pulse per channel.
REQ-011 SHALL have port down  output  N_CH  one-cycle falling-edge pulse per channel.
REQ-012 SHALL have port pending  output  N_CH  sticky mode-qualified edge flags.
REQ-013 SHALL have port irq  output  1  OR of (pending & irq_en).

Function
REQ-014 Each a[i] SHALL pass through SYNC_STAGES flops; sync_out[i] is the last stage.
REQ-015 Each channel SHALL hold a filtered level lvl[i] and counter cnt[i] of width $clog2(FILT_LEN+1).
REQ-016 If sync_out[i]==lvl[i], cnt[i] SHALL clear to 0.
REQ-017 If sync_out[i]!=lvl[i] and cnt[i]==FILT_LEN-1, lvl[i] SHALL take sync_out[i] and cnt[i] SHALL clear; otherwise cnt[i] SHALL increment.
REQ-018 rise[i] SHALL be registered high for exactly one cycle, at the same edge lvl[i] goes 0->1; down[i] likewise for 1->0; never both high.
REQ-019 rise/down SHALL be unqualified by mode.
REQ-020 Latency from the first clock edge sampling a new stable a[i] to rise/down high SHALL be SYNC_STAGES+FILT_LEN-1 cycles.
REQ-021 An input differing from lvl for fewer than FILT_LEN consecutive synchronised cycles SHALL produce no pulse and no pending.
REQ-022 pending[i] next = (pending[i] & ~clr[i]) | qualified edge, qualified edge = (rise-next & mode bit0) | (down-next & mode bit1); set SHALL win over simultaneous clr.
REQ-023 clr on a non-pending channel SHALL have no effect; mode changes SHALL not alter existing pending bits.
REQ-024 irq SHALL be combinational from pending and irq_en registers/inputs, no extra latency.
REQ-025 Channels SHALL be fully independent; simultaneous edges on any subset SHALL all be reported in the same cycle.

Reset
REQ-026 rst_n low SHALL asynchronously clear all sync flops, lvl, cnt, rise, down, pending; irq thus 0.
REQ-027 Reset mid-filter SHALL discard partial count; an input held high across reset release SHALL yield a rise after REQ-020 latency.

Configuration
REQ-028 Macro EDGE_DETECT_FILTER_EN defined: glitch filter per REQ-015..REQ-017 compiled in.
REQ-029 Macro undefined: cnt removed, lvl[i] <= sync_out[i] every cycle, FILT_LEN ignored, latency SYNC_STAGES cycles, any synchronised pulse of one cycle or more detected.

Verification (N_CH=4, SYNC_STAGES=2, FILT_LEN=3, filter enabled unless noted)
REQ-030 a[0] 0->1 held, mode[1:0]=01, irq_en=0001 -> rise=0001 for one cycle 4 edges after sampling, pending[0]=1, irq=1; clr=0001 one cycle -> pending=0, irq=0.
REQ-031 a[1] high 2 cycles then low -> rise/down/pending stay 0; same stimulus with EDGE_DETECT_FILTER_EN undefined -> rise[1] then down[1] pulses.
REQ-032 mode[5:4]=11, a[2] high 10 cycles -> rise[2] then down[2] 10 cycles later; clr[2] asserted in the down-pulse cycle -> pending[2] remains 1.
REQ-033 mode[7:6]=00, a[3] toggles stably -> rise[3]/down[3] pulse, pending[3]=0, irq=0.
REQ-034 a=1111 simultaneously, mode all 01 -> rise=1111 in one cycle, pending=1111.
REQ-035 rst_n low after 1 filter cycle with a[0] high -> all outputs 0 immediately; release with a[0] held high -> rise[0] after 4 cycles.
